ic_test_controller: RTL and testbench



---
 rtl/ic_test_controller.sv | 141 ++++++++++++++
 tb/tb_ic_test_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ic_test_controller.sv
// ============================================================================
// ic_test_controller : sequences one multi-round run of the 6-gate IC checkers
// Rev 1.0
// ============================================================================
`default_nettype none

module ic_test_controller #(
  parameter int ROUND_CYCLES = 100000002,
  parameter int ROUNDS       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] gate_pass,
  input  logic [5:0] gate_fail,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic [5:0] gate_ok,
  output logic       ic_pass,
  output logic       ic_fail,
  output logic       unstable
);

  localparam int CYC_W = $clog2(ROUND_CYCLES);
  localparam int RND_W = $clog2(ROUNDS) + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(ROUND_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             start_q;
  logic             start_edge;
  logic             cyc_term;
  logic             last_round;
  logic [CYC_W-1:0] cyc_cnt;
  logic [RND_W-1:0] round_cnt;
  logic [11:0]      snap;
  logic [11:0]      prev;
  logic [5:0]       ok_calc;

  assign start_edge = start & ~start_q;
  assign cyc_term   = (cyc_cnt == CYC_LAST);
  assign last_round = (round_cnt == RND_LAST);

  // A gate is good only if it passed in the last round and both of its bits
  // match the round before.
  for (genvar i = 0; i < 6; i++) begin : g_gate
    assign ok_calc[i] = snap[i] & ~snap[i+6]
                      & (snap[i] == prev[i]) & (snap[i+6] == prev[i+6]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_edge) state_next = S_RUN;
      S_RUN:   if (cyc_term && last_round) state_next = S_EVAL;
      S_EVAL:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Resetting high keeps a button held through reset from starting a test.
      start_q   <= 1'b1;
      enable    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gate_ok   <= '0;
      ic_pass   <= 1'b0;
      ic_fail   <= 1'b0;
      unstable  <= 1'b0;
      cyc_cnt   <= '0;
      round_cnt <= '0;
      snap      <= '0;
      prev      <= '0;
    end else begin
      start_q <= start;
      enable  <= (state == S_RUN) && !abort;
      busy    <= ((state == S_RUN) || (state == S_EVAL)) && !abort;
      done    <= (state == S_DONE) && !abort;

      if (abort) begin
        gate_ok  <= '0;
        ic_pass  <= 1'b0;
        ic_fail  <= 1'b0;
        unstable <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_edge) begin
              gate_ok   <= '0;
              ic_pass   <= 1'b0;
              ic_fail   <= 1'b0;
              unstable  <= 1'b0;
              cyc_cnt   <= '0;
              round_cnt <= '0;
              snap      <= '0;
              prev      <= '0;
            end
          end
          S_RUN: begin
            cyc_cnt <= cyc_term ? '0 : cyc_cnt + 1'b1;
            if (cyc_term) begin
              prev      <= snap;
              snap      <= {gate_fail, gate_pass};
              round_cnt <= round_cnt + 1'b1;
            end
          end
          S_EVAL: begin
            gate_ok  <= ok_calc;
            unstable <= (snap != prev);
            ic_pass  <= &ok_calc;
            ic_fail  <= ~(&ok_calc);
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ic_test_controller.sv
// ============================================================================
// tb_ic_test_controller : directed scoreboard bench for ic_test_controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ic_test_controller;

  localparam int RC = 8;
  localparam int RN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] gate_pass = '0;
  logic [5:0] gate_fail = '0;
  logic       enable, busy, done, ic_pass, ic_fail, unstable;
  logic [5:0] gate_ok;

  typedef struct packed {
    logic [5:0] ok;
    logic       p;
    logic       f;
    logic       u;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ic_test_controller #(.ROUND_CYCLES(RC), .ROUNDS(RN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gate_pass(gate_pass), .gate_fail(gate_fail),
    .enable(enable), .busy(busy), .done(done), .gate_ok(gate_ok),
    .ic_pass(ic_pass), .ic_fail(ic_fail), .unstable(unstable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] ok, input logic p, input logic f, input logic u);
    res_t r;
    r.ok = ok; r.p = p; r.f = f; r.u = u;
    sb.push_back(r);
  endtask

  task automatic compare_sb(input string tag);
    res_t r;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb_empty: observed 0 expected 1", tag);
    end
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check({tag, "_gate_ok"}, 32'(gate_ok), 32'(r.ok));
      check({tag, "_ic_pass"}, 32'(ic_pass), 32'(r.p));
      check({tag, "_ic_fail"}, 32'(ic_fail), 32'(r.f));
      check({tag, "_unstable"}, 32'(unstable), 32'(r.u));
      check({tag, "_one_verdict"}, 32'(ic_pass ^ ic_fail), 32'd1);
    end
  endtask

  // Ends on a negedge with start just raised; that cycle is latency cycle 1.
  task automatic start_test();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int lat, output int en_cycles, output bit seen);
    lat = 1; en_cycles = 0; seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      lat++;
      if (enable) en_cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_en(input int n, output bit ok);
    int cnt;
    cnt = 0; ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (enable) cnt++;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_watch(input int n, output int en_seen, output int done_seen);
    en_seen = 0; done_seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (enable) en_seen++;
      if (done) done_seen++;
    end
  endtask

  initial begin
    int  lat, en, dn;
    bit  seen, ok;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_results", 32'({gate_ok, ic_pass, ic_fail, unstable}), 32'd0);

    // 1: all gates good
    gate_pass = 6'h3F; gate_fail = 6'h00;
    push_exp(6'h3F, 1'b1, 1'b0, 1'b0);
    start_test();
    wait_done(100, lat, en, seen);
    check("t1_done_seen", 32'(seen), 32'd1);
    check("t1_latency", 32'(lat), 32'd28);
    check("t1_enable_cycles", 32'(en), 32'd24);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    compare_sb("t1");
    @(negedge clk);
    check("t1_done_width", 32'(done), 32'd0);
    check("t1_held_ok", 32'(gate_ok), 32'h3F);

    // 2: gate 3 bad
    gate_pass = 6'h3B; gate_fail = 6'h04;
    push_exp(6'h3B, 1'b0, 1'b1, 1'b0);
    start_test();
    wait_done(100, lat, en, seen);
    check("t2_done_seen", 32'(seen), 32'd1);
    check("t2_enable_cycles", 32'(en), 32'd24);
    compare_sb("t2");

    // 3: gate 6 flips to fail in the last round
    gate_pass = 6'h3F; gate_fail = 6'h00;
    push_exp(6'h1F, 1'b0, 1'b1, 1'b1);
    start_test();
    wait_en(20, ok);
    check("t3_reach_en20", 32'(ok), 32'd1);
    gate_pass = 6'h1F; gate_fail = 6'h20;
    wait_done(100, lat, en, seen);
    check("t3_done_seen", 32'(seen), 32'd1);
    compare_sb("t3");

    // 4: abort mid-run, then a full run
    gate_pass = 6'h3F; gate_fail = 6'h00;
    start_test();
    wait_en(10, ok);
    check("t4_reach_en10", 32'(ok), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_enable", 32'(enable), 32'd0);
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_results", 32'({gate_ok, ic_pass, ic_fail, unstable}), 32'd0);
    idle_watch(40, en, dn);
    check("t4_idle_enable", 32'(en), 32'd0);
    check("t4_no_done", 32'(dn), 32'd0);
    push_exp(6'h3F, 1'b1, 1'b0, 1'b0);
    start_test();
    wait_done(100, lat, en, seen);
    check("t4_done_seen", 32'(seen), 32'd1);
    check("t4_latency", 32'(lat), 32'd28);
    check("t4_enable_cycles", 32'(en), 32'd24);
    compare_sb("t4");

    // 5: start held through reset, then toggled during RUN
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_watch(40, en, dn);
    check("t5_held_no_enable", 32'(en), 32'd0);
    check("t5_held_no_done", 32'(dn), 32'd0);
    push_exp(6'h3F, 1'b1, 1'b0, 1'b0);
    start_test();
    dn = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k < 20) start = ~start;
      else start = 1'b0;
      if (done) begin
        dn++;
        if (dn == 1) compare_sb("t5");
      end
    end
    check("t5_done_count", 32'(dn), 32'd1);
    sb.delete();

    // 6: asynchronous reset mid-run
    gate_pass = 6'h3B; gate_fail = 6'h04;
    start_test();
    wait_en(15, ok);
    check("t6_reach_en15", 32'(ok), 32'd1);
    check("t6_pre_rst_enable", 32'(enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_enable", 32'(enable), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_results", 32'({done, gate_ok, ic_pass, ic_fail, unstable}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(40, en, dn);
    check("t6_post_rst_enable", 32'(en), 32'd0);
    check("t6_post_rst_done", 32'(dn), 32'd0);
    push_exp(6'h3B, 1'b0, 1'b1, 1'b0);
    start_test();
    wait_done(100, lat, en, seen);
    check("t6_done_seen", 32'(seen), 32'd1);
    check("t6_latency", 32'(lat), 32'd28);
    compare_sb("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
